// File: rtl/signal_period_monitor.sv
// signal_period_monitor
// Synchronises an asynchronous square wave, times its high and low halves in
// clock cycles, qualifies each half against programmable limits and reports
// a one-cycle result strobe, sticky fault flags and a lock indication.
module signal_period_monitor #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sig_in,
  input  logic [CNT_WIDTH-1:0] min_half,
  input  logic [CNT_WIDTH-1:0] max_half,
  input  logic                 clear_flags,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] low_time,
  output logic [CNT_WIDTH:0]   period,
  output logic                 valid,
  output logic                 too_short,
  output logic                 too_long,
  output logic                 locked
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_HIGH    = 2'd2,
    ST_LOW     = 2'd3
  } state_e;

  logic [1:0]             rst_sync_q;
  logic                   rst_n_s;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_s;
  logic                   s_d_q;
  logic                   rise_q;
  logic                   fall_q;
  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic [CNT_WIDTH-1:0]   high_q;
  logic [CNT_WIDTH-1:0]   low_q;
  logic [CNT_WIDTH:0]     period_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   hi_ok_q;
  logic [1:0]             streak_q;
  logic                   too_short_q;
  logic                   too_long_q;
  logic                   edge_s;
  logic                   measuring_s;
  logic                   capture_s;
  logic                   timeout_s;
  logic                   short_s;
  logic                   in_range_s;

  // Reset bridge: assertion reaches every flop at once, release is re-timed to clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Input synchroniser followed by registered rise/fall detection.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s_s;
      rise_q <= s_s & ~s_d_q;
      fall_q <= ~s_s & s_d_q;
    end
  end

  assign s_s = sync_q[SYNC_STAGES-1];

  // Counter next value and the range/timeout qualifiers seen by the FSM.
  always_comb begin
    edge_s      = rise_q | fall_q;
    measuring_s = (state_q == ST_HIGH) || (state_q == ST_LOW);
    if (edge_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    capture_s  = enable && (((state_q == ST_HIGH) && fall_q) || ((state_q == ST_LOW) && rise_q));
    timeout_s  = enable && measuring_s && !edge_s && (cnt_q > max_half);
    short_s    = capture_s && (cnt_q < min_half);
    in_range_s = (cnt_q >= min_half) && (cnt_q <= max_half);
  end

  // Measurement FSM: counter, capture registers, lock tracking and valid strobe.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      high_q   <= CNT_ZERO;
      low_q    <= CNT_ZERO;
      period_q <= {(CNT_WIDTH+1){1'b0}};
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      hi_ok_q  <= 1'b0;
      streak_q <= 2'd0;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        state_q  <= ST_IDLE;
        cnt_q    <= CNT_ZERO;
        locked_q <= 1'b0;
        streak_q <= 2'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQUIRE;
            cnt_q   <= CNT_ZERO;
          end
          ST_ACQUIRE: begin
            cnt_q <= cnt_d;
            if (rise_q) begin
              state_q <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            cnt_q <= cnt_d;
            if (timeout_s) begin
              state_q  <= ST_ACQUIRE;
              locked_q <= 1'b0;
              streak_q <= 2'd0;
            end else if (fall_q) begin
              high_q  <= cnt_q;
              hi_ok_q <= in_range_s;
              state_q <= ST_LOW;
              if (short_s) begin
                locked_q <= 1'b0;
                streak_q <= 2'd0;
              end
            end
          end
          ST_LOW: begin
            cnt_q <= cnt_d;
            if (timeout_s) begin
              state_q  <= ST_ACQUIRE;
              locked_q <= 1'b0;
              streak_q <= 2'd0;
            end else if (rise_q) begin
              low_q    <= cnt_q;
              period_q <= {1'b0, high_q} + {1'b0, cnt_q};
              valid_q  <= 1'b1;
              state_q  <= ST_HIGH;
              if (hi_ok_q && in_range_s) begin
                // Second consecutive good period (or later) holds lock.
                if (streak_q != 2'd0) begin
                  streak_q <= 2'd2;
                  locked_q <= 1'b1;
                end else begin
                  streak_q <= 2'd1;
                end
              end else begin
                streak_q <= 2'd0;
                if (short_s) begin
                  locked_q <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Sticky fault flags; a new fault in the clearing cycle keeps the flag set.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      too_short_q <= 1'b0;
      too_long_q  <= 1'b0;
    end else begin
      too_short_q <= short_s   ? 1'b1 : (clear_flags ? 1'b0 : too_short_q);
      too_long_q  <= timeout_s ? 1'b1 : (clear_flags ? 1'b0 : too_long_q);
    end
  end

  assign high_time = high_q;
  assign low_time  = low_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign too_short = too_short_q;
  assign too_long  = too_long_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_signal_period_monitor.sv
// Bench for signal_period_monitor: segment-based stimulus, a half-period level
// reference model feeding a scoreboard queue, and a monitor popping on valid.
module tb_signal_period_monitor;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        sig_in;
  logic [15:0] min_half;
  logic [15:0] max_half;
  logic        clear_flags;
  logic [15:0] high_time;
  logic [15:0] low_time;
  logic [16:0] period;
  logic        valid;
  logic        too_short;
  logic        too_long;
  logic        locked;

  signal_period_monitor #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .min_half   (min_half),
    .max_half   (max_half),
    .clear_flags(clear_flags),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .valid      (valid),
    .too_short  (too_short),
    .too_long   (too_long),
    .locked     (locked)
  );

  typedef struct {
    int hi;
    int lo;
    int per;
    bit ts;
    bit tl;
    bit lk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   seg_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_min;
  int m_max;
  bit m_too_short;
  bit m_too_long;
  bit m_locked;
  int m_streak;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard monitor: every valid pops one expected result
  always @(negedge clock) begin
    if (valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got high=%0d low=%0d period=%0d, no result expected",
                 high_time, low_time, period);
      end else begin
        mon_e = sb_q.pop_front();
        if (high_time != 16'(mon_e.hi) || low_time != 16'(mon_e.lo) || period != 17'(mon_e.per) ||
            too_short != mon_e.ts || too_long != mon_e.tl || locked != mon_e.lk) begin
          errors++;
          $display("FAIL valid_result: got h=%0d l=%0d p=%0d ts=%0b tl=%0b lk=%0b, want h=%0d l=%0d p=%0d ts=%0b tl=%0b lk=%0b",
                   high_time, low_time, period, too_short, too_long, locked,
                   mon_e.hi, mon_e.lo, mon_e.per, mon_e.ts, mon_e.tl, mon_e.lk);
        end
      end
    end
  end

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_high_time"}, high_time, 0);
    check_val({tag, "_low_time"}, low_time, 0);
    check_val({tag, "_period"}, period, 0);
    check_val({tag, "_valid"}, valid, 0);
    check_val({tag, "_too_short"}, too_short, 0);
    check_val({tag, "_too_long"}, too_long, 0);
    check_val({tag, "_locked"}, locked, 0);
  endtask

  // Reference model: walks the list of half-periods (alternating, high first)
  // that follow entry to ACQUIRE and predicts every reported period.
  task automatic model_phase();
    bit   acq;
    bit   hi_ok;
    bit   ok;
    bit   lvl;
    int   hi;
    int   d;
    exp_t e;
    acq = 1'b1; hi_ok = 1'b0; hi = 0;
    m_locked = 1'b0; m_streak = 0;
    for (int i = 0; i < seg_q.size(); i++) begin
      lvl = (i % 2 == 0);
      d   = seg_q[i];
      if (acq && !lvl) continue;
      acq = 1'b0;
      if (d >= m_max + 2) begin
        m_too_long = 1'b1; m_locked = 1'b0; m_streak = 0; acq = 1'b1;
        continue;
      end
      if (d < m_min) begin
        m_too_short = 1'b1; m_locked = 1'b0; m_streak = 0;
      end
      ok = (d >= m_min) && (d <= m_max);
      if (lvl) begin
        hi = d; hi_ok = ok;
      end else begin
        if (hi_ok && ok) begin
          m_streak++;
          if (m_streak >= 2) m_locked = 1'b1;
        end else begin
          m_streak = 0;
        end
        e.hi = hi; e.lo = d; e.per = hi + d;
        e.ts = m_too_short; e.tl = m_too_long; e.lk = m_locked;
        sb_q.push_back(e);
      end
    end
  endtask

  // Drives seg_q as levels held for whole cycles, then an opposite-level tail.
  task automatic drive_phase(input int tail_n);
    for (int i = 0; i < seg_q.size(); i++) begin
      sig_in = (i % 2 == 0);
      repeat (seg_q[i]) @(negedge clock);
    end
    sig_in = (seg_q.size() % 2 == 0);
    repeat (tail_n) @(negedge clock);
  endtask

  task automatic run_phase(input string tag);
    @(negedge clock);
    sig_in = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    model_phase();
    drive_phase(6);
    check_val({tag, "_locked_end"}, locked, m_locked);
    enable = 1'b0;
    m_locked = 1'b0; m_streak = 0;
    repeat (4) @(negedge clock);
    check_val({tag, "_pending_results"}, sb_q.size(), 0);
    check_val({tag, "_too_short"}, too_short, m_too_short);
    check_val({tag, "_too_long"}, too_long, m_too_long);
    check_val({tag, "_locked_idle"}, locked, 0);
  endtask

  task automatic clear_pulse();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    m_too_short = 1'b0; m_too_long = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    int d;
    reset_n = 1'b0; enable = 1'b0; sig_in = 1'b0; clear_flags = 1'b0;
    m_min = 2; m_max = 10;
    min_half = 16'(m_min); max_half = 16'(m_max);
    m_too_short = 1'b0; m_too_long = 1'b0; m_locked = 1'b0; m_streak = 0;

    // reset and idle
    repeat (5) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    check_all_zero("idle");

    // nominal lock
    seg_q.delete();
    for (int i = 0; i < 6; i++) begin seg_q.push_back(5); seg_q.push_back(3); end
    run_phase("nominal");

    // single too-short high pulse
    seg_q = '{5, 3, 5, 3, 1, 3, 5, 3};
    run_phase("short");
    check_val("short_flag_set", too_short, 1);
    clear_pulse();
    check_val("short_flag_cleared", too_short, 0);

    // stuck high after lock, then relock
    seg_q = '{5, 3, 5, 3, 5, 3, 20, 3, 5, 3, 5, 3};
    run_phase("long");
    check_val("long_flag_set", too_long, 1);
    clear_pulse();
    check_val("long_flag_cleared", too_long, 0);

    // clear_flags in the very cycle the timeout is detected
    @(negedge clock);
    sig_in = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clock);
    sig_in = 1'b1;
    @(posedge clock);
    repeat (3 + m_max) @(posedge clock);
    @(negedge clock);
    check_val("collision_before_fault", too_long, 0);
    clear_flags = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear_flags = 1'b0;
    check_val("collision_fault_wins", too_long, 1);
    enable = 1'b0;
    sig_in = 1'b0;
    m_too_long = 1'b1;
    clear_pulse();
    check_val("collision_cleared", too_long, 0);

    // asynchronous reset while measuring a low half
    @(negedge clock);
    sig_in = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    seg_q = '{5, 3};
    model_phase();
    drive_phase(5);
    sig_in = 1'b0;
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check_val("async_reset_pending", sb_q.size(), 0);
    sb_q.delete();
    m_too_short = 1'b0; m_too_long = 1'b0; m_locked = 1'b0; m_streak = 0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    seg_q = '{5, 3, 5, 3};
    run_phase("after_reset");

    // randomized phases with random limits
    for (int p = 0; p < 8; p++) begin
      m_min = int'($urandom_range(2, 4));
      m_max = int'($urandom_range(m_min + 4, 12));
      min_half = 16'(m_min); max_half = 16'(m_max);
      if ($urandom_range(0, 1) == 1) clear_pulse();
      n = int'($urandom_range(6, 14));
      seg_q.delete();
      for (int k = 0; k < n; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 75)      d = int'($urandom_range(m_min, m_max));
        else if (r < 87) d = int'($urandom_range(1, m_min - 1));
        else             d = int'($urandom_range(m_max + 2, m_max + 6));
        seg_q.push_back(d);
      end
      run_phase("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
